// File: rtl/ram_capture_ctrl.sv
// ram_capture_ctrl
//   Trigger-based sample capture controller in front of a single-port ram
//   (registered read address, 1-cycle read latency).
//   - While armed, valid samples are written circularly into the ram.
//   - Capture freezes after the trigger sample plus POST_TRIG further samples.
//   - The whole buffer is then streamed out oldest-first over valid/ready.
//   Optional feature: define TRIG_ADDR_EN to add output trig_addr, the ram
//   address of the trigger sample.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   smpl, smpl_vld      incoming sample stream
//   arm                 1-cycle pulse, starts a capture (IDLE only)
//   trig                trigger level, seen only in ARMED with smpl_vld=1
//   dout, dout_vld      readout data / valid
//   dout_rdy            consumer ready
//   armed, done         status: capturing / reading out
//   ram_data, ram_addr, ram_we, ram_q   ram interface
//   trig_addr           (TRIG_ADDR_EN only) ram address of the trigger sample
module ram_capture_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned POST_TRIG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] smpl,
    input  logic                  smpl_vld,
    input  logic                  arm,
    input  logic                  trig,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  armed,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
`ifdef TRIG_ADDR_EN
    output logic [ADDR_WIDTH-1:0] trig_addr,
`endif
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   RD_END   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   POST_END = (ADDR_WIDTH+1)'(POST_TRIG);

    typedef enum logic [1:0] {IDLE, ARMED, POST, READ} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] post_cnt, post_cnt_nxt;
    logic [ADDR_WIDTH:0]   rd_cnt, rd_cnt_nxt;
    logic [ADDR_WIDTH:0]   post_inc;
    logic                  vld_q, vld_nxt;
    logic                  issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            post_cnt <= '0;
            rd_cnt   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            post_cnt <= post_cnt_nxt;
            rd_cnt   <= rd_cnt_nxt;
            vld_q    <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        post_cnt_nxt = post_cnt;
        rd_cnt_nxt   = rd_cnt;
        vld_nxt      = vld_q;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_data     = '0;
        post_inc     = {1'b0, post_cnt} + CNT_ONE;
        issue        = 1'b0;

        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt    = ARMED;
                    wr_ptr_nxt   = '0;
                    post_cnt_nxt = '0;
                    rd_cnt_nxt   = '0;
                end
            end
            ARMED: begin
                if (smpl_vld) begin
                    ram_we     = 1'b1;
                    ram_addr   = wr_ptr;
                    ram_data   = smpl;
                    wr_ptr_nxt = wr_ptr + PTR_ONE;
                    if (trig) begin
                        state_nxt    = (POST_TRIG == 0) ? READ : POST;
                        post_cnt_nxt = '0;
                        rd_cnt_nxt   = '0;
                    end
                end
            end
            POST: begin
                if (smpl_vld) begin
                    ram_we       = 1'b1;
                    ram_addr     = wr_ptr;
                    ram_data     = smpl;
                    wr_ptr_nxt   = wr_ptr + PTR_ONE;
                    post_cnt_nxt = post_inc[ADDR_WIDTH-1:0];
                    if (post_inc == POST_END) begin
                        state_nxt  = READ;
                        rd_cnt_nxt = '0;
                    end
                end
            end
            READ: begin
                // rd_cnt counts addresses issued to the ram. A new address is
                // issued when the output register is empty or being drained;
                // otherwise the address of the beat on dout is re-presented so
                // ram_q (and dout) stays stable during a stall.
                issue = (!vld_q || dout_rdy) && (rd_cnt != RD_END);
                if (issue) begin
                    ram_addr   = wr_ptr + rd_cnt[ADDR_WIDTH-1:0];
                    rd_cnt_nxt = rd_cnt + CNT_ONE;
                    vld_nxt    = 1'b1;
                end else begin
                    ram_addr = wr_ptr + rd_cnt[ADDR_WIDTH-1:0] - PTR_ONE;
                    if (vld_q && dout_rdy) begin
                        vld_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TRIG_ADDR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trig_addr <= '0;
        else if (state == ARMED && smpl_vld && trig)
            trig_addr <= wr_ptr;
    end
`endif

    // dout is ram_q qualified by valid so that every output reads 0 in reset/idle.
    assign dout     = vld_q ? ram_q : '0;
    assign dout_vld = vld_q;
    assign armed    = (state == ARMED) || (state == POST);
    assign done     = (state == READ);

endmodule

// File: tb/tb_ram_capture_ctrl.sv
module tb_ram_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] smpl = '0;
    logic       smpl_vld = 1'b0;
    logic       trig = 1'b0;
    logic       arm1 = 1'b0, arm0 = 1'b0;
    logic       dout_rdy = 1'b1;
    bit         rdy_toggle = 1'b0;

    logic [7:0] dout1, dout0, ram_data1, ram_data0, ram_q1, ram_q0;
    logic [2:0] ram_addr1, ram_addr0;
    logic       dout_vld1, dout_vld0, armed1, armed0, done1, done0, ram_we1, ram_we0;
`ifdef TRIG_ADDR_EN
    logic [2:0] ta1, ta0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    ram_capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .POST_TRIG(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .smpl(smpl), .smpl_vld(smpl_vld), .arm(arm1),
        .trig(trig), .dout(dout1), .dout_vld(dout_vld1), .dout_rdy(dout_rdy),
        .armed(armed1), .done(done1), .ram_data(ram_data1), .ram_addr(ram_addr1),
        .ram_we(ram_we1),
`ifdef TRIG_ADDR_EN
        .trig_addr(ta1),
`endif
        .ram_q(ram_q1));

    ram_capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .POST_TRIG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .smpl(smpl), .smpl_vld(smpl_vld), .arm(arm0),
        .trig(trig), .dout(dout0), .dout_vld(dout_vld0), .dout_rdy(dout_rdy),
        .armed(armed0), .done(done0), .ram_data(ram_data0), .ram_addr(ram_addr0),
        .ram_we(ram_we0),
`ifdef TRIG_ADDR_EN
        .trig_addr(ta0),
`endif
        .ram_q(ram_q0));

    // single-port ram models: registered read address, 1-cycle latency
    logic [7:0] mem1[8];
    logic [7:0] mem0[8];
    logic [2:0] a1q = '0, a0q = '0;
    initial for (int i = 0; i < 8; i++) begin mem1[i] = '0; mem0[i] = '0; end
    always @(posedge clk) begin
        if (ram_we1) mem1[ram_addr1] <= ram_data1;
        if (ram_we0) mem0[ram_addr0] <= ram_data0;
        a1q <= ram_addr1;
        a0q <= ram_addr0;
    end
    assign ram_q1 = mem1[a1q];
    assign ram_q0 = mem0[a0q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ready driver: steady high, or alternating when rdy_toggle is set
    initial forever begin
        @(posedge clk); #1;
        dout_rdy = rdy_toggle ? ~dout_rdy : 1'b1;
    end

    // monitors: pop expected beat on each accepted beat, check stability when stalled
    initial begin
        logic       st1, st0;
        logic [7:0] sv1, sv0;
        st1 = 1'b0; st0 = 1'b0; sv1 = '0; sv0 = '0;
        forever begin
            @(negedge clk);
            if (st1 && dout_vld1) chk("stall_stable1", dout1, sv1);
            if (st0 && dout_vld0) chk("stall_stable0", dout0, sv0);
            if (dout_vld1 && dout_rdy) begin
                if (q1.size() == 0) chk("extra_beat1", dout1, 32'hFFFF_FFFF);
                else chk("beat1", dout1, q1.pop_front());
            end
            if (dout_vld0 && dout_rdy) begin
                if (q0.size() == 0) chk("extra_beat0", dout0, 32'hFFFF_FFFF);
                else chk("beat0", dout0, q0.pop_front());
            end
            st1 = dout_vld1 && !dout_rdy; sv1 = dout1;
            st0 = dout_vld0 && !dout_rdy; sv0 = dout0;
        end
    end

    task automatic cyc(input logic [7:0] s, input logic v, input logic t);
        smpl = s; smpl_vld = v; trig = t;
        @(posedge clk); #1;
    endtask

    // arm one DUT then feed n consecutive samples base.., trigger on index tidx
    task automatic cap(input bit which, input int base, input int n, input int tidx);
        if (which) arm1 = 1'b1; else arm0 = 1'b1;
        @(posedge clk); #1;
        arm1 = 1'b0; arm0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            smpl = 8'(base + i); smpl_vld = 1'b1; trig = (i == tidx);
            if (i == 0) begin
                #1;
                chk("first_wr_addr", which ? ram_addr1 : ram_addr0, 0);
            end
            @(posedge clk); #1;
        end
        smpl_vld = 1'b0; trig = 1'b0;
    endtask

    task automatic readout(input bit which);
        for (int c = 0; c < 200; c++) begin
            if (!(which ? done1 : done0)) break;
            @(posedge clk); #1;
        end
        chk("done_fall", which ? done1 : done0, 0);
        chk("vld_after_end", which ? dout_vld1 : dout_vld0, 0);
        chk("all_beats_seen", which ? q1.size() : q0.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_dout", dout1, 0);
        chk("rst_dout_vld", dout_vld1, 0);
        chk("rst_armed", armed1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ram_we", ram_we1, 0);
        chk("rst_ram_addr", ram_addr1, 0);
        chk("rst_ram_data", ram_data1, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // basic capture: 1..10, trig on 6 -> 3..10
        for (int k = 3; k <= 10; k++) q1.push_back(8'(k));
        cap(1'b1, 1, 10, 5);
        chk("done_after_post", done1, 1);
        readout(1'b1);

        // stalled readout: 21..28, trig on 24
        rdy_toggle = 1'b1;
        for (int k = 21; k <= 28; k++) q1.push_back(8'(k));
        cap(1'b1, 21, 8, 3);
        readout(1'b1);
        rdy_toggle = 1'b0;
        @(posedge clk); #1;

        // sample gaps in POST: writes 31..39, oldest-first 32..39
        for (int k = 32; k <= 39; k++) q1.push_back(8'(k));
        cap(1'b1, 31, 5, 4);
        chk("armed_in_post", armed1, 1);
        cyc(8'd36, 1'b1, 1'b0);
        smpl = 8'd90; smpl_vld = 1'b0; #1; chk("gap_we_a", ram_we1, 0);
        @(posedge clk); #1;
        cyc(8'd37, 1'b1, 1'b0);
        smpl_vld = 1'b0; #1; chk("gap_we_b", ram_we1, 0);
        @(posedge clk); #1;
        cyc(8'd91, 1'b0, 1'b0);
        cyc(8'd38, 1'b1, 1'b0);
        chk("still_post", armed1, 1);
        chk("not_done_yet", done1, 0);
        cyc(8'd39, 1'b1, 1'b0);
        smpl_vld = 1'b0;
        chk("done_after_gaps", done1, 1);
        readout(1'b1);

        // 15 samples, trig on 11th (addr 10 mod 8 = 2), oldest-first 108..115
        for (int k = 108; k <= 115; k++) q1.push_back(8'(k));
        cap(1'b1, 101, 15, 10);
`ifdef TRIG_ADDR_EN
        chk("trig_addr", ta1, 2);
`endif
        readout(1'b1);

        // POST_TRIG=0: fill with 1..8, then trig on first sample 99
        for (int k = 1; k <= 8; k++) q0.push_back(8'(k));
        cap(1'b0, 1, 8, 7);
        readout(1'b0);
        for (int k = 2; k <= 8; k++) q0.push_back(8'(k));
        q0.push_back(8'd99);
        cap(1'b0, 99, 1, 0);
        chk("pt0_read_next", done0, 1);
        readout(1'b0);

        // reset mid-POST, then re-arm restarts at address 0
        cap(1'b1, 41, 5, 3);
        smpl = 8'd46; smpl_vld = 1'b1;
        rst_n = 1'b0; #1;
        chk("abort_dout", dout1, 0);
        chk("abort_dout_vld", dout_vld1, 0);
        chk("abort_armed", armed1, 0);
        chk("abort_done", done1, 0);
        chk("abort_ram_we", ram_we1, 0);
        chk("abort_ram_addr", ram_addr1, 0);
        chk("abort_ram_data", ram_data1, 0);
        @(posedge clk); #1; rst_n = 1'b1; smpl_vld = 1'b0;
        @(posedge clk); #1;
        for (int k = 55; k <= 62; k++) q1.push_back(8'(k));
        cap(1'b1, 51, 12, 7);
        readout(1'b1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
